stream_mux_rr: RTL and testbench

//   N-channel registered stream multiplexer with round-robin arbitration and valid/ready handshake.

---
 rtl/stream_mux_rr.sv | 119 +++++++++++
 tb/tb_stream_mux_rr.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// Round-robin registered stream multiplexer: N valid/ready producers merged onto one consumer.
// Optional packet lock (define STREAM_MUX_PKT_LOCK_EN) holds the grant until the end of a packet.
module stream_mux_rr #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] chan_data [CHANNELS];
    logic [SEL_W-1:0] rr_ptr_reg;
    logic [SEL_W-1:0] arb_grant;
    logic [SEL_W-1:0] arb_idx;
    logic             arb_found;
    logic [SEL_W-1:0] grant;
    logic             grant_ok;
    logic             space;
    logic             xfer;

    logic [WIDTH-1:0] out_data_reg;
    logic             out_last_reg;
    logic [SEL_W-1:0] out_sel_reg;
    logic             out_valid_reg;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi]  = !reset && grant_ok && space && (grant == SEL_W'(gi));
        end
    endgenerate

    // Scan starts just after the last winner, so the winner drops to lowest priority.
    always_comb begin
        arb_grant = '0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            arb_idx = SEL_W'((int'(rr_ptr_reg) + k) % CHANNELS);
            if (!arb_found && in_valid[arb_idx]) begin
                arb_found = 1'b1;
                arb_grant = arb_idx;
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} lock_state_t;

    lock_state_t      lock_state_reg;
    logic [SEL_W-1:0] lock_ch_reg;

    // While locked the owner keeps the grant even when it is momentarily not valid.
    assign grant    = (lock_state_reg == LOCKED) ? lock_ch_reg : arb_grant;
    assign grant_ok = (lock_state_reg == LOCKED) || (|in_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state_reg <= IDLE;
            lock_ch_reg    <= '0;
        end else if (xfer) begin
            case (lock_state_reg)
                IDLE: begin
                    if (!in_last[grant]) begin
                        lock_state_reg <= LOCKED;
                        lock_ch_reg    <= grant;
                    end
                end
                LOCKED: begin
                    if (in_last[lock_ch_reg]) begin
                        lock_state_reg <= IDLE;
                    end
                end
                default: lock_state_reg <= IDLE;
            endcase
        end
    end
`else
    assign grant    = arb_grant;
    assign grant_ok = |in_valid;
`endif

    assign space = !out_valid_reg || out_ready;
    assign xfer  = !reset && grant_ok && in_valid[grant] && space;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_sel_reg   <= '0;
            rr_ptr_reg    <= SEL_W'(CHANNELS - 1);
        end else if (xfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= chan_data[grant];
            out_last_reg  <= in_last[grant];
            out_sel_reg   <= grant;
            rr_ptr_reg    <= grant;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign out_sel   = out_sel_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed table-driven bench for stream_mux_rr (4 channels, 10-bit data); follows
// STREAM_MUX_PKT_LOCK_EN so the packet rows match whichever build is compiled.
module tb_stream_mux_rr;

    localparam int WIDTH    = 10;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;
    localparam int NROWS    = 25;

    logic                      clk;
    logic                      reset;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_last;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_last;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      out_ready;

    logic [WIDTH-1:0] chan_val [CHANNELS];

    typedef struct {
        logic [3:0] vld;
        logic [3:0] lst;
        logic       ordy;
        logic [3:0] exp_ir;
        logic       exp_ov;
        logic [1:0] exp_sel;
        logic       exp_ol;
    } vec_t;

    vec_t tbl [NROWS];
    int   checks   = 0;
    int   failures = 0;

    stream_mux_rr #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_last (out_last),
        .out_sel  (out_sel),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign in_data = {chan_val[3], chan_val[2], chan_val[1], chan_val[0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        chan_val[0] = 10'h0A0;
        chan_val[1] = 10'h0B1;
        chan_val[2] = 10'h155;
        chan_val[3] = 10'h0D3;

        // Single-beat traffic, round robin, lone channel, ch1/ch3 ordering, consumer stall.
        tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 1'b1};
        tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 1'b1};
        tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 1'b1};
        tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 1'b1};
        tbl[5]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 1'b1};
        tbl[6]  = '{4'h4, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 1'b1};
        tbl[7]  = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 1'b1};
        tbl[8]  = '{4'hA, 4'hF, 1'b1, 4'h8, 1'b0, 2'd2, 1'b1};
        tbl[9]  = '{4'hA, 4'hF, 1'b1, 4'h2, 1'b1, 2'd3, 1'b1};
        tbl[10] = '{4'hA, 4'hF, 1'b1, 4'h8, 1'b1, 2'd1, 1'b1};
        tbl[11] = '{4'hA, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 1'b1};
        tbl[12] = '{4'hA, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 1'b1};
        tbl[13] = '{4'hA, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 1'b1};
        tbl[14] = '{4'hA, 4'hF, 1'b1, 4'h2, 1'b1, 2'd3, 1'b1};
        tbl[15] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 1'b1};
        tbl[16] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd1, 1'b1};
`ifdef STREAM_MUX_PKT_LOCK_EN
        // ch1 3-beat packet against ch0, with a ch1 gap mid-packet.
        tbl[17] = '{4'h1, 4'h1, 1'b1, 4'h1, 1'b0, 2'd1, 1'b1};
        tbl[18] = '{4'h3, 4'h0, 1'b1, 4'h2, 1'b1, 2'd0, 1'b1};
        tbl[19] = '{4'h3, 4'h0, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0};
        tbl[20] = '{4'h1, 4'h0, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0};
        tbl[21] = '{4'h1, 4'h0, 1'b1, 4'h2, 1'b0, 2'd1, 1'b0};
        tbl[22] = '{4'h3, 4'h2, 1'b1, 4'h2, 1'b0, 2'd1, 1'b0};
        tbl[23] = '{4'h1, 4'h1, 1'b1, 4'h1, 1'b1, 2'd1, 1'b1};
        tbl[24] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 1'b1};
`else
        // Same packet stimulus without lock: channels alternate every beat.
        tbl[17] = '{4'h1, 4'h0, 1'b1, 4'h1, 1'b0, 2'd1, 1'b1};
        tbl[18] = '{4'h3, 4'h0, 1'b1, 4'h2, 1'b1, 2'd0, 1'b0};
        tbl[19] = '{4'h3, 4'h0, 1'b1, 4'h1, 1'b1, 2'd1, 1'b0};
        tbl[20] = '{4'h3, 4'h0, 1'b1, 4'h2, 1'b1, 2'd0, 1'b0};
        tbl[21] = '{4'h3, 4'h0, 1'b1, 4'h1, 1'b1, 2'd1, 1'b0};
        tbl[22] = '{4'h3, 4'h2, 1'b1, 4'h2, 1'b1, 2'd0, 1'b0};
        tbl[23] = '{4'h1, 4'h0, 1'b1, 4'h1, 1'b1, 2'd1, 1'b1};
        tbl[24] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 1'b0};
`endif

        // Reset held two cycles with every channel valid.
        reset     = 1'b1;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("reset%0d_out_valid", c), 32'(out_valid), 32'd0);
            chk($sformatf("reset%0d_out_sel", c), 32'(out_sel), 32'd0);
            chk($sformatf("reset%0d_out_data", c), 32'(out_data), 32'd0);
            chk($sformatf("reset%0d_in_ready", c), 32'(in_ready), 32'd0);
        end
        reset = 1'b0;

        for (int r = 0; r < NROWS; r++) begin
            in_valid  = tbl[r].vld;
            in_last   = tbl[r].lst;
            out_ready = tbl[r].ordy;
            #1;
            $display("row %0d vld=%h rdy=%b in_ready=%h out_valid=%b out_sel=%0d out_data=%h out_last=%b",
                     r, in_valid, out_ready, in_ready, out_valid, out_sel, out_data, out_last);
            chk($sformatf("row%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].exp_ir));
            chk($sformatf("row%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].exp_ov));
            chk($sformatf("row%0d_out_sel", r), 32'(out_sel), 32'(tbl[r].exp_sel));
            chk($sformatf("row%0d_out_last", r), 32'(out_last), 32'(tbl[r].exp_ol));
            if (tbl[r].exp_ov)
                chk($sformatf("row%0d_out_data", r), 32'(out_data), 32'(chan_val[tbl[r].exp_sel]));
            @(negedge clk);
        end

        // Beat stalled in the output register, then reset drops it and any lock.
        in_valid  = 4'h4;
        in_last   = 4'h0;
        out_ready = 1'b0;
        #1;
        chk("midpkt_in_ready", 32'(in_ready), 32'h4);
        @(negedge clk);
        $display("midpkt out_valid=%b out_sel=%0d out_data=%h", out_valid, out_sel, out_data);
        chk("midpkt_out_valid", 32'(out_valid), 32'd1);
        chk("midpkt_out_data", 32'(out_data), 32'h155);
        chk("midpkt_stall_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        $display("after reset out_valid=%b out_sel=%0d out_data=%h", out_valid, out_sel, out_data);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        reset     = 1'b0;
        in_valid  = 4'h3;
        in_last   = 4'h3;
        out_ready = 1'b1;
        #1;
        chk("postrst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        chk("postrst_out_valid", 32'(out_valid), 32'd1);
        chk("postrst_out_sel", 32'(out_sel), 32'd0);
        chk("postrst_out_data", 32'(out_data), 32'h0A0);

        // New data on ch0 must propagate, and a lone channel wins from any pointer.
        chan_val[0] = 10'h3C5;
        in_valid    = 4'h1;
        in_last     = 4'h1;
        #1;
        chk("newdata_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        $display("newdata out_valid=%b out_sel=%0d out_data=%h", out_valid, out_sel, out_data);
        chk("newdata_out_data", 32'(out_data), 32'h3C5);
        chk("newdata_out_sel", 32'(out_sel), 32'd0);
        chk("newdata_out_last", 32'(out_last), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
